// File: rtl/sparse_pkg.sv
// rtl/sparse_pkg.sv - shared widths, state encoding and magnitude helper for the sparse packer
package sparse_pkg;

  localparam int D_WIDTH_DEF = 16;
  localparam int I_WIDTH_DEF = 4;
  localparam int ABS_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One extra bit so the most-negative input still yields a positive magnitude.
  function automatic logic [ABS_W:0] abs_mag(input logic [ABS_W-1:0] x);
    logic [ABS_W:0] e;
    e = {x[ABS_W-1], x};
    return x[ABS_W-1] ? (~e + (ABS_W+1)'(1)) : e;
  endfunction

endpackage

// File: rtl/sparse_packer_if.sv
// rtl/sparse_packer_if.sv - dense input stream plus FIFO write port of the sparse packer
interface sparse_packer_if #(
  parameter int D_WIDTH = 16,
  parameter int I_WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] in_data;
  logic               fifo_full;
  logic               w_en;
  logic [D_WIDTH-1:0] data_out;
  logic [I_WIDTH-1:0] index_out;

  modport master (
    input  in_valid, in_data, fifo_full,
    output in_ready, w_en, data_out, index_out
  );

  modport slave (
    output in_valid, in_data, fifo_full,
    input  in_ready, w_en, data_out, index_out
  );
endinterface

// File: rtl/sparse_packer.sv
// rtl/sparse_packer.sv - drops near-zero elements of a dense vector and emits (data, index) pairs
module sparse_packer
  import sparse_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int I_WIDTH = I_WIDTH_DEF,
  parameter int THRESH  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  sparse_packer_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic [I_WIDTH:0] nnz_count
);

  state_t             state;
  logic               pend_valid;
  logic [D_WIDTH-1:0] pend_data;
  logic [I_WIDTH-1:0] pend_idx;
  logic [I_WIDTH-1:0] idx;
  logic [I_WIDTH:0]   nnz;

  logic               accept;
  logic               kept;
  logic [ABS_W-1:0]   in_ext;

  // Gating with rst keeps the FIFO untouched on a reset cycle.
  assign bus.w_en      = rst & pend_valid & ~bus.fifo_full;
  assign bus.in_ready  = rst & (state == RUN) & (~pend_valid | ~bus.fifo_full);
  assign bus.data_out  = pend_data;
  assign bus.index_out = pend_idx;
  assign busy          = (state != IDLE);

  assign accept = bus.in_valid & bus.in_ready;
  assign in_ext = {{(ABS_W-D_WIDTH){bus.in_data[D_WIDTH-1]}}, bus.in_data};
  assign kept   = abs_mag(in_ext) > (ABS_W+1)'(THRESH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_idx   <= '0;
      idx        <= '0;
      nnz        <= '0;
      nnz_count  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.w_en)
        pend_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            idx   <= '0;
            nnz   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (kept) begin
              pend_valid <= 1'b1;
              pend_data  <= bus.in_data;
              pend_idx   <= idx;
              nnz        <= nnz + (I_WIDTH+1)'(1);
            end
            idx <= idx + I_WIDTH'(1);
            if (idx == {I_WIDTH{1'b1}})
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pend_valid || bus.w_en) begin
            state     <= IDLE;
            done      <= 1'b1;
            nnz_count <= nnz;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sparse_packer.md
Name: sparse_packer

Overview:
- Producer side of the sparse value/index FIFO.
- Accepts one dense vector of 2**I_WIDTH signed elements over a valid/ready stream and drops elements whose magnitude is at or below a threshold.
- Writes each surviving element into the FIFO write port as a (data, index) pair, honouring fifo_full.
- Sits between the layer-output datapath and the FIFO that feeds the sparse MAC stage.

Parameters:
- D_WIDTH, 16, element width (two's complement).
- I_WIDTH, 4, index width; vector length is 2**I_WIDTH.
- THRESH, 0, elements with |x| <= THRESH are treated as zero (unsigned, < 2**(D_WIDTH-1)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a vector; ignored unless state is IDLE.
- in_valid  in  1  dense element valid.
- in_ready  out  1  element accepted on the cycle when in_valid & in_ready.
- in_data  in  D_WIDTH  dense element.
- fifo_full  in  1  FIFO full flag.
- w_en  out  1  FIFO write enable.
- data_out  out  D_WIDTH  FIFO data_in.
- index_out  out  I_WIDTH  FIFO index_in.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of vector.
- nnz_count  out  I_WIDTH+1  number of pairs written for the last vector; valid from done onward.

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-low: sampled only at posedge clk.

Reset (rst=0 at posedge clk):
- State goes to IDLE.
- pend_valid, done, idx and nnz_count are all 0.
- data_out and index_out are 0.
- Outputs after reset: w_en=0, in_ready=0, busy=0.
- Reset mid-vector discards the pending pair and the partial count. No write is issued on the reset cycle.

Pending register (one entry: pend_valid, pend_data, pend_idx):
- data_out = pend_data; index_out = pend_idx (registered).
- w_en = pend_valid & ~fifo_full (combinational). The FIFO captures the pair on the same edge.
- A pair is "written" on any cycle with w_en=1; pend_valid clears on that edge unless reloaded.

States:
- IDLE:
  - in_ready=0.
  - start -> RUN. On that edge: idx=0, nnz=0, done=0.
- RUN:
  - in_ready = ~pend_valid | ~fifo_full. This allows one accept per cycle while the FIFO is not full.
  - On accept, the element is "kept" when |in_data| > THRESH. Magnitude is computed at D_WIDTH+1 bits so that the most-negative value does not overflow.
  - On a kept accept: pend loads (in_data, idx), pend_valid=1, nnz increments.
  - On a dropped accept: pend_valid clears if it was written this cycle; otherwise it holds.
  - Every accept increments idx.
  - On the accept with idx = 2**I_WIDTH-1, go to DRAIN. idx wraps to 0.
- DRAIN:
  - in_ready=0.
  - When pend_valid=0, or pend_valid=1 with w_en=1 this cycle: go to IDLE on the next edge, pulse done for one cycle in IDLE, and latch nnz into nnz_count.
  - fifo_full held high keeps the block in DRAIN indefinitely.

Boundary conditions:
- start while busy is ignored.
- in_valid while IDLE is never accepted.
- An all-zero vector writes nothing; done fires with nnz_count=0.
- A fully dense vector gives nnz_count = 2**I_WIDTH, so the count needs I_WIDTH+1 bits.
- fifo_full rising while pend_valid=1 stalls both w_en and in_ready. The pair is held unchanged, with no loss and no duplication.
- Throughput is 1 element/cycle when the FIFO has room. Latency from a kept accept to w_en is 1 cycle.
- A pair is written exactly once and in index order. Indices are strictly increasing within a vector.

Decomposition:
- Shared package sparse_pkg:
  - D_WIDTH and I_WIDTH defaults.
  - State enum: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - abs-magnitude function.
- No sub-module. A single block is natural; the threshold compare stays inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 and start=1 -> w_en=0, in_ready=0, busy=0, done=0, data_out=0, index_out=0.
- Mixed vector, THRESH=0: start, then elements x[i]=i for i odd and 0 for i even, fifo_full=0 -> 8 writes (1,1),(3,3)...(15,15), each 1 cycle after its accept. done fires with nnz_count=8.
- Threshold: THRESH=2, elements 0,-2,3,-3,2,16'h8000, rest 0 -> writes (3,2),(-3,3),(16'h8000,5). nnz_count=3.
- Backpressure: dense vector of all 5s, fifo_full=1 for cycles 3-7 after start -> in_ready low and pair held stable while full. Exactly 16 writes with indices 0..15, no gaps or repeats. nnz_count=16.
- Stall in DRAIN: last element nonzero with fifo_full=1 -> state stays DRAIN, done=0. Drop fifo_full -> w_en for index 15, then done the next cycle.
- Reset mid-vector: rst=0 after 7 accepts -> IDLE, no further writes. A new start then produces a correct full vector with indices starting at 0.
